mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch requester, the load/store requester, and an optional debug/loader requester. Grants one requester at a time in round-robin order. Sequences each access as setup, strobe and response so that memory op, address and write data are stable for a full cycle before the memory strobe and throughout it. Sits between the core control logic and the memory module, replacing direct stage-based muxing of the memory op and address.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  3  request per port: [0] fetch, [1] load/store, [2] debug
- `op0`/`op1`/`op2`  in  3 each  memory op per port, passed to memory unmodified
- `addr0`/`addr1`/`addr2`  in  ADDR_W each  address per port
- `wdata0`/`wdata1`/`wdata2`  in  DATA_W each  write data per port
- `ack`  out  3  one-cycle completion pulse per port
- `rdata`  out  DATA_W  response data, valid while any `ack` bit is high
- `rfault`  out  1  response fault, valid while any `ack` bit is high
- `busy`  out  1  high in every state except IDLE
- `mem_en`  out  1  memory strobe, used to gate the memory clock
- `mem_op`  out  3  registered memory op
- `mem_addr`  out  ADDR_W  registered memory address
- `mem_wdata`  out  DATA_W  registered memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `mem_fault`  in  1  memory fault

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP, all registered.
- IDLE:
  - If any enabled `req` bit is high, pick a winner by round robin.
  - Latch the winner's op, addr and wdata into `mem_op`/`mem_addr`/`mem_wdata`.
  - Record the winner index, then go to SETUP.
  - If no enabled request is high, stay in IDLE.
- SETUP: memory outputs hold; `mem_en`=0. Go to ACCESS.
- ACCESS: `mem_en`=1 for exactly this cycle. Capture `mem_rdata` and `mem_fault` into `rdata`/`rfault` at the closing edge. Go to RESP.
- RESP: `ack[winner]`=1 and all other `ack` bits 0. Update the round-robin pointer to the winner. Go to IDLE.
- Round robin:
  - Search starts at (pointer+1) mod N and wraps.
  - N=3 with debug, N=2 without.
  - The reset pointer equals the last port, so fetch (port 0) wins the first tie.
- Requester rules:
  - Hold `req`, op, addr and wdata stable until `ack` is seen.
  - Deassert `req` in the cycle after `ack`, or keep it high to request again.
  - `req` dropping mid-transaction does not abort the access; `ack` still pulses.
  - Input changes after the IDLE latch edge are ignored until the next grant.
- `mem_op`, `mem_addr` and `mem_wdata` change only at the IDLE→SETUP edge. This keeps them stable for the cycle before `mem_en` and during it.
- `rdata`/`rfault` hold their last captured value outside RESP.
- Reset: asynchronous, active-low.
  - State = IDLE; all outputs = 0; pointer = last port.
  - A reset mid-transaction abandons the access with no `ack`.
  - `mem_en` drops immediately on reset assertion.

## Timing
- Grant-to-ack latency: `req` sampled high in IDLE at edge T gives SETUP in T..T+1, ACCESS in T+1..T+2, and `ack` high in T+2..T+3.
- Occupancy: 4 cycles per access including the return to IDLE. Maximum throughput is one access per 4 cycles.
- Simultaneous requests: exactly one winner per IDLE cycle. Losers wait, with no starvation: worst-case wait is (N−1) accesses after the current one.
- Memory must complete combinationally within the ACCESS cycle. There is no wait-state support.

## Configuration
- `MEM_ARB_DEBUG_EN` defined:
  - Port 2 participates in arbitration; N=3.
- Not defined:
  - `req[2]`, `op2`, `addr2` and `wdata2` are ignored.
  - `ack[2]` is tied to 0.
  - Round robin runs over ports 0 and 1 only; reset pointer = 1.
  - Port list is unchanged.

## Test plan
- Single fetch: after reset, `req`=001, addr0=0x100, op0=010, `mem_rdata`=0xDEADBEEF.
  - `mem_en` high exactly in the 2nd cycle after grant.
  - `ack`=001 in the 3rd cycle with `rdata`=0xDEADBEEF, `rfault`=0.
- Contention: `req`=111 held continuously (debug enabled).
  - Grant order 0,1,2,0,1,2.
  - `ack` bits spaced 4 cycles apart; `mem_addr` matches each winner's address.
- Stability: change addr1 from 0x200 to 0x300 during SETUP/ACCESS of a port-1 grant.
  - `mem_addr` stays 0x200 until the next grant.
- Fault: `mem_fault`=1 during ACCESS.
  - `rfault`=1 with the matching `ack`; the next clean access returns `rfault`=0.
- Reset mid-access: assert `reset`=0 during ACCESS.
  - `mem_en`, `busy` and `ack` go to 0 immediately.
  - After release, `req`=011 grants port 0 first.
- Macro off: `req`=100.
  - State stays IDLE and `ack` stays 000.
  - With `req`=111, the grant order is 0,1,0,1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one memory port between fetch, load/store and debug requesters.
// The debug port takes part only when MEM_ARB_DEBUG_EN is defined. Each access runs as setup, strobe, response.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        op0,
  input  logic [2:0]        op1,
  input  logic [2:0]        op2,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rfault,
  output logic              busy,
  output logic              mem_en,
  output logic [2:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_fault
);

`ifdef MEM_ARB_DEBUG_EN
  localparam int NPORTS = 3;
`else
  localparam int NPORTS = 2;
`endif
  localparam logic [1:0] LAST_PORT = 2'(NPORTS - 1);
  localparam logic [2:0] PORT_MASK = 3'((1 << NPORTS) - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e              state_q;
  logic [1:0]          ptr_q;
  logic [1:0]          win_q;
  logic [2:0]          ack_q;
  logic                busy_q;
  logic                mem_en_q;
  logic [2:0]          mem_op_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rfault_q;

  logic [2:0]          req_m;
  logic                win_vld_d;
  logic [1:0]          win_d;
  logic [1:0]          idx;
  logic [2:0]          sel_op_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;

  assign req_m = req & PORT_MASK;

  // Walk from the farthest candidate to the nearest so the port right after the pointer wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    win_vld_d = 1'b0;
    win_d     = 2'd0;
    idx       = 2'd0;
    for (int i = NPORTS; i >= 1; i--) begin
      idx = 2'((int'(ptr_q) + i) % NPORTS);
      if (req_m[idx]) begin
        win_vld_d = 1'b1;
        win_d     = idx;
      end
    end
  end

  always_comb begin
    sel_op_d    = op0;
    sel_addr_d  = addr0;
    sel_wdata_d = wdata0;
    case (win_d)
      2'd1: begin
        sel_op_d    = op1;
        sel_addr_d  = addr1;
        sel_wdata_d = wdata1;
      end
`ifdef MEM_ARB_DEBUG_EN
      2'd2: begin
        sel_op_d    = op2;
        sel_addr_d  = addr2;
        sel_wdata_d = wdata2;
      end
`endif
      default: ;
    endcase
  end

`ifndef MEM_ARB_DEBUG_EN
  logic unused_dbg;
  assign unused_dbg = ^{req[2], op2, addr2, wdata2};
`endif

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all control and datapath registers reset, so a reset mid-access leaves no stale strobe or ack.
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= LAST_PORT;
      win_q       <= 2'd0;
      ack_q       <= 3'b000;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_op_q    <= 3'b000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      rfault_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register in this block sees pre-edge values.
      ack_q <= 3'b000;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            win_q       <= win_d;
            mem_op_q    <= sel_op_d;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            busy_q      <= 1'b1;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          mem_en_q <= 1'b1;
          state_q  <= ACCESS;
        end
        ACCESS: begin
          mem_en_q <= 1'b0;
          rdata_q  <= mem_rdata;
          rfault_q <= mem_fault;
          ack_q    <= (3'b001 << win_q) & PORT_MASK;
          state_q  <= RESP;
        end
        RESP: begin
          ptr_q   <= win_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign rfault    = rfault_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_op    = mem_op_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifndef SYNTHESIS
  a_strobe_in_access: assert property (@(posedge clk) disable iff (!reset)
    mem_en_q |-> (state_q == ACCESS));
  a_ack_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(ack_q));
  a_ack_in_resp: assert property (@(posedge clk) disable iff (!reset)
    (ack_q != 3'b000) |-> (state_q == RESP));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expectations, and a negedge monitor
// compares the strobe phase and the ack response against them. Contention order follows MEM_ARB_DEBUG_EN.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef MEM_ARB_DEBUG_EN
  localparam int N_CONT = 6;
  localparam int N_TB   = 3;
`else
  localparam int N_CONT = 4;
  localparam int N_TB   = 2;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        req = 3'b000;
  logic [2:0]        op0 = '0, op1 = '0, op2 = '0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
  logic [2:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic              rfault;
  logic              busy;
  logic              mem_en;
  logic [2:0]        mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_fault;
  logic              fault_inj = 1'b0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .req(req),
    .op0(op0), .op1(op1), .op2(op2),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .ack(ack), .rdata(rdata), .rfault(rfault), .busy(busy),
    .mem_en(mem_en), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  // Memory stand-in: one fixed word at 0x100, every other address reads back addr ^ 0xFFFF0000.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hFFFF_0000);
  endfunction
  assign mem_rdata = mem_en ? mem_word(mem_addr) : '0;
  assign mem_fault = mem_en & fault_inj;

  typedef struct {
    logic [1:0]        port;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              fault;
  } exp_t;

  exp_t sb[$];
  int   ack_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   en_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [1:0] p, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] w, input logic [31:0] r, input logic f);
    exp_t e;
    e.port = p; e.op = o; e.addr = a; e.wdata = w; e.rdata = r; e.fault = f;
    sb.push_back(e);
  endtask

  // Monitor: strobe phase checked against the head entry, ack pops it.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_en) begin
        if (sb.size() == 0) check("strobe_unexpected", 64'(mem_en), 64'd0);
        else begin
          check("mem_addr", 64'(mem_addr), 64'(sb[0].addr));
          check("mem_op", 64'(mem_op), 64'(sb[0].op));
          check("mem_wdata", 64'(mem_wdata), 64'(sb[0].wdata));
        end
        en_cyc = cyc;
      end
      if (ack != 3'b000) begin
        if (sb.size() == 0) check("ack_unexpected", 64'(ack), 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_port", 64'(ack), 64'(3'b001 << e.port));
          check("rdata", 64'(rdata), 64'(e.rdata));
          check("rfault", 64'(rfault), 64'(e.fault));
          check("ack_after_strobe", 64'(cyc - en_cyc), 64'd1);
          ack_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic wait_acks(input int n, input int budget, input string name);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (ack != 3'b000) got++;
    end
    req = 3'b000;
    if (got < n) check(name, 64'(got), 64'(n));
  endtask

  task automatic do_access(input logic [1:0] p);
    req = 3'b001 << p;
    wait_acks(1, 12, "access_timeout");
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req = 3'b000;
    reset = 1'b0;
    #1;
    check("rst_outputs", 64'({busy, mem_en, ack, rfault}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    check("por_ctrl", 64'({busy, mem_en, ack, rfault}), 64'd0);
    check("por_data", 64'({mem_op, mem_addr, mem_wdata, rdata}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single fetch with cycle-exact latency
    addr0 = 32'h100; op0 = 3'b010; wdata0 = 32'h0;
    push_exp(2'd0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);
    req = 3'b001;
    @(posedge clk); #1;
    check("setup_busy_en", 64'({busy, mem_en}), 64'b10);
    check("setup_addr", 64'(mem_addr), 64'h100);
    @(posedge clk); #1;
    check("access_en", 64'(mem_en), 64'd1);
    @(posedge clk); #1;
    check("resp_ack", 64'({ack, mem_en}), 64'b0010);
    check("resp_rdata", 64'(rdata), 64'hDEAD_BEEF);
    @(negedge clk);
    req = 3'b000;
    @(posedge clk); #1;
    check("idle_after_resp", 64'({busy, ack}), 64'd0);
    @(negedge clk);

    // Stability: addr1 changes during SETUP must not reach mem_addr
    addr1 = 32'h200; op1 = 3'b100; wdata1 = 32'h1111_2222;
    push_exp(2'd1, 3'b100, 32'h200, 32'h1111_2222, 32'hFFFF_0200, 1'b0);
    req = 3'b010;
    @(posedge clk);
    @(negedge clk);
    addr1 = 32'h300;
    wait_acks(1, 10, "stab_timeout");
    @(negedge clk);
    check("mem_addr_hold", 64'(mem_addr), 64'h200);
    push_exp(2'd1, 3'b100, 32'h300, 32'h1111_2222, 32'hFFFF_0300, 1'b0);
    do_access(2'd1);

    // Fault, then a clean access clears rfault
    addr0 = 32'h400; op0 = 3'b001; wdata0 = 32'h44;
    fault_inj = 1'b1;
    push_exp(2'd0, 3'b001, 32'h400, 32'h44, 32'hFFFF_0400, 1'b1);
    do_access(2'd0);
    fault_inj = 1'b0;
    check("rfault_hold", 64'(rfault), 64'd1);
    check("rdata_hold", 64'(rdata), 64'hFFFF_0400);
    addr1 = 32'h500; op1 = 3'b110; wdata1 = 32'h55;
    push_exp(2'd1, 3'b110, 32'h500, 32'h55, 32'hFFFF_0500, 1'b0);
    do_access(2'd1);

    // Contention from reset: all requests held
    apply_reset();
    addr0 = 32'h1000; op0 = 3'b001; wdata0 = 32'hA0;
    addr1 = 32'h2000; op1 = 3'b010; wdata1 = 32'hB1;
    addr2 = 32'h3000; op2 = 3'b011; wdata2 = 32'hC2;
    for (int i = 0; i < N_CONT; i++) begin
      case (i % N_TB)
        0:       push_exp(2'd0, 3'b001, 32'h1000, 32'hA0, 32'hFFFF_1000, 1'b0);
        1:       push_exp(2'd1, 3'b010, 32'h2000, 32'hB1, 32'hFFFF_2000, 1'b0);
        default: push_exp(2'd2, 3'b011, 32'h3000, 32'hC2, 32'hFFFF_3000, 1'b0);
      endcase
    end
    ack_cyc.delete();
    @(negedge clk);
    req = 3'b111;
    wait_acks(N_CONT, 8 * N_CONT, "contention_timeout");
    @(negedge clk);
    check("contention_acks", 64'(ack_cyc.size()), 64'(N_CONT));
    for (int i = 1; i < ack_cyc.size(); i++)
      check("ack_spacing", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd4);

    // Reset during ACCESS abandons the access
    addr0 = 32'h600; op0 = 3'b010; wdata0 = 32'h66;
    push_exp(2'd0, 3'b010, 32'h600, 32'h66, 32'hFFFF_0600, 1'b0);
    req = 3'b001;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_reset_strobe", 64'(mem_en), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("reset_drop", 64'({mem_en, busy, ack}), 64'd0);
    sb.delete();
    req = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    addr0 = 32'h700; op0 = 3'b011; wdata0 = 32'h77;
    addr1 = 32'h800; op1 = 3'b101; wdata1 = 32'h88;
    push_exp(2'd0, 3'b011, 32'h700, 32'h77, 32'hFFFF_0700, 1'b0);
    push_exp(2'd1, 3'b101, 32'h800, 32'h88, 32'hFFFF_0800, 1'b0);
    req = 3'b011;
    wait_acks(2, 16, "post_reset_timeout");
    @(negedge clk);

    // Debug port alone
    apply_reset();
    addr2 = 32'h900; op2 = 3'b111; wdata2 = 32'h99;
    @(negedge clk);
`ifdef MEM_ARB_DEBUG_EN
    push_exp(2'd2, 3'b111, 32'h900, 32'h99, 32'hFFFF_0900, 1'b0);
    do_access(2'd2);
`else
    req = 3'b100;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("dbg_ignored", 64'({busy, mem_en, ack}), 64'd0);
    end
    req = 3'b000;
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
